// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: core (C) and external agent (X).
// Optional macro DMEM_ARBITER_RR_EN selects round-robin on simultaneous IDLE requests (default: C wins).
module dmem_arbiter #(
    parameter int AWIDTH   = 12,
    parameter int DWIDTH   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                c_req_i,
    input  logic                c_lock_i,
    input  logic [AWIDTH-1:0]   c_addr_i,
    input  logic [DWIDTH-1:0]   c_wdata_i,
    input  logic                c_wen_i,
    input  logic [DWIDTH/8-1:0] c_ben_i,
    output logic                c_gnt_o,
    output logic                c_rvalid_o,
    output logic [DWIDTH-1:0]   c_rdata_o,
    input  logic                x_req_i,
    input  logic                x_lock_i,
    input  logic [AWIDTH-1:0]   x_addr_i,
    input  logic [DWIDTH-1:0]   x_wdata_i,
    input  logic                x_wen_i,
    input  logic [DWIDTH/8-1:0] x_ben_i,
    output logic                x_gnt_o,
    output logic                x_rvalid_o,
    output logic [DWIDTH-1:0]   x_rdata_o,
    output logic [AWIDTH-1:0]   mem_addr_o,
    output logic [DWIDTH-1:0]   mem_wdata_o,
    output logic                mem_wen_o,
    output logic [DWIDTH/8-1:0] mem_ben_o,
    input  logic [DWIDTH-1:0]   mem_rdata_i
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, OWN_C, OWN_X} state_e;
    typedef enum logic [1:0] {RD_NONE, RD_C, RD_X} rd_owner_e;

    state_e    state_q, state_d;
    rd_owner_e rd_owner_q, rd_owner_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    state_e    idle_pick;

`ifdef DMEM_ARBITER_RR_EN
    // last_x_q = 1 means X was the most recent owner; reset value favours C.
    logic last_x_q, last_x_d;
    assign idle_pick = last_x_q ? OWN_C : OWN_X;

    always_comb begin
        last_x_d = last_x_q;
        if (state_d == OWN_C && state_q != OWN_C) last_x_d = 1'b0;
        if (state_d == OWN_X && state_q != OWN_X) last_x_d = 1'b1;
    end
`else
    assign idle_pick = OWN_C;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (c_req_i && x_req_i) state_d = idle_pick;
                else if (c_req_i)       state_d = OWN_C;
                else if (x_req_i)       state_d = OWN_X;
            end
            OWN_C: begin
                if (!c_req_i && !c_lock_i)
                    state_d = x_req_i ? OWN_X : IDLE;
                else if (x_req_i && !c_lock_i && wait_cnt_q == WAIT_LAST)
                    state_d = OWN_X;
            end
            OWN_X: begin
                if (!x_req_i && !x_lock_i)
                    state_d = c_req_i ? OWN_C : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Starvation counter only runs while X is kept waiting by C; it saturates at the threshold.
    always_comb begin
        wait_cnt_d = '0;
        if (state_q == OWN_C && x_req_i && state_d != OWN_X)
            wait_cnt_d = (wait_cnt_q == WAIT_LAST) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end

    always_comb begin
        c_gnt_o     = 1'b0;
        x_gnt_o     = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_ben_o   = '0;
        mem_wen_o   = 1'b0;
        case (state_q)
            OWN_C: begin
                c_gnt_o     = c_req_i;
                mem_addr_o  = c_addr_i;
                mem_wdata_o = c_wdata_i;
                mem_ben_o   = c_ben_i;
                mem_wen_o   = c_req_i & c_wen_i;
            end
            OWN_X: begin
                x_gnt_o     = x_req_i;
                mem_addr_o  = x_addr_i;
                mem_wdata_o = x_wdata_i;
                mem_ben_o   = x_ben_i;
                mem_wen_o   = x_req_i & x_wen_i;
            end
            default: ;
        endcase
    end

    // Read return follows the requester that issued the beat, independent of the current owner.
    always_comb begin
        rd_owner_d = RD_NONE;
        if (c_gnt_o && !c_wen_i)      rd_owner_d = RD_C;
        else if (x_gnt_o && !x_wen_i) rd_owner_d = RD_X;
    end

    assign c_rvalid_o = (rd_owner_q == RD_C);
    assign x_rvalid_o = (rd_owner_q == RD_X);
    assign c_rdata_o  = c_rvalid_o ? mem_rdata_i : '0;
    assign x_rdata_o  = x_rvalid_o ? mem_rdata_i : '0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            rd_owner_q <= RD_NONE;
            wait_cnt_q <= '0;
`ifdef DMEM_ARBITER_RR_EN
            last_x_q   <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            rd_owner_q <= rd_owner_d;
            wait_cnt_q <= wait_cnt_d;
`ifdef DMEM_ARBITER_RR_EN
            last_x_q   <= last_x_d;
`endif
        end
    end

endmodule
